// File: rtl/axi4_lite_req_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_req_arbiter
//
// Shares one AXI4-Lite master between NUM_REQ requesters. A winner is picked
// in IDLE (round-robin from rr_ptr, or fixed lowest-index-first when
// ARB_FIXED_PRIO_EN is defined). Its address, write data and direction are
// latched and a one-cycle START_READ/START_WRITE pulse goes to the master.
// The block then snoops the R or B handshake to detect completion and returns
// the read data and response to the owner with a one-cycle done pulse.
// Exactly one transaction is in flight at a time.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                      undefined -> round-robin (default)
//
// Ports:
//   ACLK, ARESETN             clock, synchronous active-low reset
//   req_valid/req_write       per-requester request and direction (1 = write)
//   req_addr/req_wdata        flattened, requester i at [i*W +: W]
//   grant                     one-hot owner, valid ISSUE..RESP
//   done                      one-cycle completion pulse to the owner
//   rsp_rdata/rsp_err         read data / captured RRESP or BRESP
//   busy                      FSM not in IDLE
//   m_start_read/write        one-cycle launch pulses to the master
//   m_address/m_wdata         request fields driven to the master
//   bus_*                     snooped R/B channel handshakes and payload
// ---------------------------------------------------------------------------
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      m_start_read,
  output logic                      m_start_write,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      bus_rvalid,
  input  logic                      bus_rready,
  input  logic                      bus_bvalid,
  input  logic                      bus_bready,
  input  logic [DATA_W-1:0]         bus_rdata,
  input  logic                      bus_rresp,
  input  logic                      bus_bresp
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             owner_wr;   // direction of the transaction in flight

  // -------------------------------------------------------------------------
  // Winner search: first pending requester at or after rr_ptr, with wrap.
  // In fixed-priority builds rr_ptr never leaves 0, so this is lowest-first.
  // -------------------------------------------------------------------------
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_write;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise a latch is inferred.
    win_found  = 1'b0;
    win_onehot = '0;
    win_write  = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found     = 1'b1;
        win_onehot[j] = 1'b1;
        win_write     = req_write[j];
        win_addr      = req_addr[j*ADDR_W +: ADDR_W];
        win_wdata     = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Pointer to the requester after the current owner, derived from grant.
  logic [IDX_W-1:0] rr_next;

  always_comb begin
    rr_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) rr_next = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
    end
  end
`endif

  // Completion handshakes; only the one matching the owner's direction counts.
  logic r_hs, b_hs;
  assign r_hs = bus_rvalid & bus_rready;
  assign b_hs = bus_bvalid & bus_bready;

  // -------------------------------------------------------------------------
  // Single FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!ARESETN) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner_wr      <= 1'b0;
      grant         <= '0;
      done          <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      m_start_read  <= 1'b0;
      m_start_write <= 1'b0;
      m_address     <= '0;
      m_wdata       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant         <= win_onehot;
            owner_wr      <= win_write;
            m_address     <= win_addr;
            m_wdata       <= win_wdata;
            m_start_write <= win_write;
            m_start_read  <= ~win_write;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Launch pulse lasts exactly this one cycle.
          m_start_read  <= 1'b0;
          m_start_write <= 1'b0;
          state         <= S_WAIT;
        end

        S_WAIT: begin
          if (owner_wr && b_hs) begin
            rsp_err <= bus_bresp;
            done    <= grant;
            state   <= S_RESP;
          end else if (!owner_wr && r_hs) begin
            rsp_rdata <= bus_rdata;
            rsp_err   <= bus_rresp;
            done      <= grant;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr    <= rr_next;
`endif
          done      <= '0;
          grant     <= '0;
          m_address <= '0;
          m_wdata   <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for axi4_lite_req_arbiter (NUM_REQ=4, 32-bit paths).
// A vector table covers single transactions; hand sequences cover stall,
// reset mid-transfer and arbitration order; a randomized phase is checked
// against a small reference model (pending set + pointer search).
// ---------------------------------------------------------------------------
module tb_axi4_lite_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      ACLK = 1'b0;
  logic                      ARESETN;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;
  logic                      m_start_read;
  logic                      m_start_write;
  logic [ADDR_W-1:0]         m_address;
  logic [DATA_W-1:0]         m_wdata;
  logic                      bus_rvalid, bus_rready, bus_bvalid, bus_bready;
  logic [DATA_W-1:0]         bus_rdata;
  logic                      bus_rresp, bus_bresp;

  axi4_lite_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .m_start_read(m_start_read), .m_start_write(m_start_write),
    .m_address(m_address), .m_wdata(m_wdata),
    .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
    .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
    .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_bresp(bus_bresp)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: arbitration pointer and last captured read data.
  int          rr_model   = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // First pending requester at or after ptr, wrapping; -1 if none.
  function automatic int model_pick(input logic [NUM_REQ-1:0] pend, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pend[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic bus_idle();
    bus_rvalid = 1'b0; bus_rready = 1'b0;
    bus_bvalid = 1'b0; bus_bready = 1'b0;
    bus_rdata  = $urandom;
    bus_rresp  = 1'($urandom_range(0, 1));
    bus_bresp  = 1'($urandom_range(0, 1));
  endtask

  task automatic set_params(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // One full transaction, entered at a negedge in IDLE with requests set up.
  task automatic serve(input string tag, input int exp_g, input int delay,
                       input bit inject, input logic [NUM_REQ-1:0] raise_mask,
                       input logic [31:0] rd_v, input logic resp_v,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    logic wr;
    logic [31:0] exp_a, exp_d;
    n = 0;
    while (!(m_start_read || m_start_write) && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (!(m_start_read || m_start_write)) begin
      check({tag, " start-timeout"}, 0, 1);
      return;
    end
    wr    = req_write[exp_g];
    exp_a = req_addr[exp_g*ADDR_W +: ADDR_W];
    exp_d = req_wdata[exp_g*DATA_W +: DATA_W];
    check({tag, " grant"}, grant, 128'(1) << exp_g);
    check({tag, " start rd/wr"}, {m_start_read, m_start_write}, {~wr, wr});
    check({tag, " m_address"}, m_address, exp_a);
    check({tag, " m_wdata"}, m_wdata, exp_d);
    check({tag, " busy"}, busy, 1);
    @(negedge ACLK);
    check({tag, " start pulse ends"}, {m_start_read, m_start_write}, 0);
    for (int d = 0; d < delay; d++) begin
      if (inject && d == 0) begin
        if (wr) begin
          bus_rvalid = 1'b1; bus_rready = 1'b1; bus_rdata = 32'hDEADBEEF; bus_rresp = 1'b1;
        end else begin
          bus_bvalid = 1'b1; bus_bready = 1'b1; bus_bresp = 1'b1;
        end
      end
      if (d == 1) begin
        if (wr) bus_bready = 1'b1;
        else    bus_rvalid = 1'b1;
      end
      if (d == delay / 2) req_valid = req_valid | raise_mask;
      @(negedge ACLK);
      bus_idle();
      check({tag, " wait no done"}, done, 0);
      check({tag, " wait stable"}, {grant, m_address, m_wdata}, {4'(1 << exp_g), exp_a, exp_d});
    end
    if (wr) begin
      bus_bvalid = 1'b1; bus_bready = 1'b1; bus_bresp = resp_v;
    end else begin
      bus_rvalid = 1'b1; bus_rready = 1'b1; bus_rdata = rd_v; bus_rresp = resp_v;
    end
    @(negedge ACLK);
    bus_idle();
    check({tag, " done"}, done, 128'(1) << exp_g);
    check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, " rsp_err"}, rsp_err, exp_err);
    req_valid[exp_g] = 1'b0;
    last_rdata = exp_rdata;
`ifdef ARB_FIXED_PRIO_EN
    rr_model = 0;
`else
    rr_model = (exp_g + 1) % NUM_REQ;
`endif
    @(negedge ACLK);
    check({tag, " back to idle"}, {done, grant, busy, m_address, m_wdata}, 0);
  endtask

  // Random bus response; expected values come from the model.
  task automatic serve_auto(input string tag, input int g, input int delay,
                            input bit inject, input logic [NUM_REQ-1:0] raise_mask);
    logic [31:0] rd;
    logic        rs;
    rd = $urandom;
    rs = 1'($urandom_range(0, 1));
    serve(tag, g, delay, inject, raise_mask, rd, rs, req_write[g] ? last_rdata : rd, rs);
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    logic        bus_resp;
    int          delay;
    bit          inject;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];
  int   exp_order[5];
  int   n_order;

  initial begin
    vecs[0] = '{0, 1'b0, 32'h10,  32'h0,        32'hCAFEF00D, 1'b0, 2, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h20,  32'hA5A5A5A5, 32'h0,        1'b1, 1, 1'b0, 32'hCAFEF00D, 1'b1};
    vecs[2] = '{1, 1'b0, 32'h44,  32'h0,        32'h12345678, 1'b0, 4, 1'b1, 32'h12345678, 1'b0};
    vecs[3] = '{3, 1'b1, 32'hFC,  32'h0BADF00D, 32'h0,        1'b0, 3, 1'b1, 32'h12345678, 1'b0};
    vecs[4] = '{0, 1'b0, 32'h100, 32'h0,        32'h00000000, 1'b1, 0, 1'b0, 32'h00000000, 1'b1};

    bus_idle();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    check("reset ctrl", {grant, done, rsp_err, busy, m_start_read, m_start_write}, 0);
    check("reset data", {rsp_rdata, m_address, m_wdata}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Single transactions from the vector table.
    foreach (vecs[v]) begin
      set_params(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      req_valid[vecs[v].idx] = 1'b1;
      serve($sformatf("vec%0d", v), vecs[v].idx, vecs[v].delay, vecs[v].inject, '0,
            vecs[v].bus_rd, vecs[v].bus_resp, vecs[v].exp_rdata, vecs[v].exp_err);
    end

    // Stall: long WAIT, req1 rises mid-transfer and must not steal the grant.
    set_params(2, 1'b0, 32'h300, 32'h0);
    set_params(1, 1'b1, 32'h204, 32'h5555AAAA);
    req_valid[2] = 1'b1;
    serve_auto("stall", 2, 20, 1'b0, 4'b0010);
    serve_auto("stall-next", 1, 1, 1'b0, '0);

    // Reset while in WAIT, with a read handshake in the reset cycle.
    set_params(0, 1'b0, 32'h80, 32'h0);
    req_valid[0] = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst-wait pre", {busy, m_start_read, m_start_write, grant}, {3'b100, 4'b0001});
    ARESETN = 1'b0;
    bus_rvalid = 1'b1; bus_rready = 1'b1; bus_rdata = 32'h77777777;
    @(negedge ACLK);
    ARESETN = 1'b1;
    bus_idle();
    req_valid = '0;
    rr_model = 0;
    last_rdata = '0;
    check("rst-wait ctrl", {grant, done, rsp_err, busy, m_start_read, m_start_write}, 0);
    check("rst-wait data", {rsp_rdata, m_address, m_wdata}, 0);
    @(negedge ACLK);
    check("rst-wait no done", {done, busy}, 0);
    set_params(3, 1'b1, 32'h3C, 32'h13579BDF);
    req_valid[3] = 1'b1;
    serve_auto("rst-fresh", 3, 2, 1'b0, '0);

    // Arbitration order with all four requesters pending.
    for (int i = 0; i < NUM_REQ; i++) set_params(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    req_valid = '1;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 1, 2, 3, 0};
    n_order   = 4;
`else
    exp_order = '{0, 1, 2, 3, 0};
    n_order   = 5;
`endif
    for (int k = 0; k < n_order; k++) begin
      serve_auto($sformatf("order%0d", k), exp_order[k], 1, 1'b0, '0);
`ifndef ARB_FIXED_PRIO_EN
      req_valid[exp_order[k]] = 1'b1;
`endif
    end
    req_valid = '0;
    @(negedge ACLK);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      int g;
      if (req_valid == '0) begin
        logic [NUM_REQ-1:0] m;
        m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        for (int i = 0; i < NUM_REQ; i++)
          if (m[i]) set_params(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        req_valid = m;
      end
      g = model_pick(req_valid, rr_model);
      serve_auto($sformatf("rand%0d", t), g, $urandom_range(0, 5), 1'($urandom_range(0, 1)), '0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_params(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          req_valid[i] = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
